// File: rtl/npu_seq_pkg.sv
// rtl/npu_seq_pkg.sv - shared types and constants for the NPU sequencer
package npu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_MAC,
      ST_RELU,
      ST_PLOAD,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int N_BYTES_DEF = 8;

   localparam logic SEL_AUTO   = 1'b1;
   localparam logic SEL_MANUAL = 1'b0;

endpackage

// File: rtl/npu_seq_ctrl_if.sv
// rtl/npu_seq_ctrl_if.sv - core-side bus: operand handshake, FIFO status and datapath strobes
interface npu_seq_ctrl_if;

   logic in_valid;
   logic in_ready;
   logic FULL;
   logic EN_BUF_IN;
   logic CLR_BUF_IN;
   logic EN_MAC;
   logic RST_MAC;
   logic EN_ReLU;
   logic EN_PISO_OUT;
   logic CLR_PISO_OUT;
   logic SHIFT_OUT;
   logic WR_EN;
   logic SEL_CON;

   modport master (
      input  in_valid, FULL,
      output in_ready, EN_BUF_IN, CLR_BUF_IN, EN_MAC, RST_MAC, EN_ReLU,
             EN_PISO_OUT, CLR_PISO_OUT, SHIFT_OUT, WR_EN, SEL_CON
   );

   modport slave (
      output in_valid, FULL,
      input  in_ready, EN_BUF_IN, CLR_BUF_IN, EN_MAC, RST_MAC, EN_ReLU,
             EN_PISO_OUT, CLR_PISO_OUT, SHIFT_OUT, WR_EN, SEL_CON
   );

endinterface

// File: rtl/npu_seq_cnt.sv
// rtl/npu_seq_cnt.sv - loadable up-counter with terminal-count flag against a latched last value
module npu_seq_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] last_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear wins over increment so an abort during the last write leaves a clean counter.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/npu_seq_ctrl.sv
// rtl/npu_seq_ctrl.sv - NPU job sequencer FSM and strobe decode; NPU_SEQ_PERF_EN adds perf counters
module npu_seq_ctrl
   import npu_seq_pkg::*;
#(
   parameter int MAC_W   = 8,
   parameter int GRP_W   = 8,
   parameter int N_BYTES = N_BYTES_DEF
) (
   input  logic             CLKEXT,
   input  logic             RST_GLO,
   input  logic             start,
   input  logic             abort,
   input  logic             manual_mode,
   input  logic [MAC_W-1:0] cfg_n_mac,
   input  logic [GRP_W-1:0] cfg_n_grp,
   npu_seq_ctrl_if.master   core,
   output logic             CTR_OUT,
   output logic             OUT_DONE,
`ifdef NPU_SEQ_PERF_EN
   output logic [31:0]      perf_cycles,
   output logic [31:0]      perf_stalls,
`endif
   output logic             busy
);

   localparam int                BYTE_W    = $clog2(N_BYTES + 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

   state_e           state_q, state_d;
   logic [MAC_W-1:0] mac_last_q, mac_last_d;
   logic [GRP_W-1:0] grp_last_q, grp_last_d;
   logic             sel_con_q, sel_con_d;
   logic             start_acc, abort_hit, cnt_clr, wr_fire;
   logic             mac_tc, grp_tc, byte_tc;

   assign start_acc = (state_q == ST_IDLE) && start && !abort;
   assign abort_hit = (state_q != ST_IDLE) && abort;
   assign cnt_clr   = start_acc || abort_hit;
   assign wr_fire   = (state_q == ST_DRAIN) && !core.FULL;

   npu_seq_cnt #(.W(MAC_W)) u_mac_cnt (
      .clk_i  (CLKEXT),
      .rst_i  (RST_GLO),
      .clr_i  (cnt_clr || (state_q == ST_CLEAR)),
      .inc_i  (state_q == ST_MAC),
      .last_i (mac_last_q),
      .tc_o   (mac_tc)
   );

   npu_seq_cnt #(.W(BYTE_W)) u_byte_cnt (
      .clk_i  (CLKEXT),
      .rst_i  (RST_GLO),
      .clr_i  (cnt_clr || (state_q == ST_CLEAR)),
      .inc_i  (wr_fire),
      .last_i (BYTE_LAST),
      .tc_o   (byte_tc)
   );

   npu_seq_cnt #(.W(GRP_W)) u_grp_cnt (
      .clk_i  (CLKEXT),
      .rst_i  (RST_GLO),
      .clr_i  (cnt_clr),
      .inc_i  (wr_fire && byte_tc && !grp_tc),
      .last_i (grp_last_q),
      .tc_o   (grp_tc)
   );

   // A zero count from the host means one step, so the latched last index saturates at 0.
   always_comb begin
      state_d    = state_q;
      mac_last_d = mac_last_q;
      grp_last_d = grp_last_q;
      sel_con_d  = sel_con_q;
      case (state_q)
         ST_IDLE: begin
            if (start_acc) begin
               state_d    = ST_CLEAR;
               mac_last_d = (cfg_n_mac == '0) ? '0 : cfg_n_mac - 1'b1;
               grp_last_d = (cfg_n_grp == '0) ? '0 : cfg_n_grp - 1'b1;
               sel_con_d  = manual_mode ? SEL_MANUAL : SEL_AUTO;
            end
         end
         ST_CLEAR: state_d = ST_LOAD;
         ST_LOAD:  if (core.in_valid) state_d = ST_MAC;
         ST_MAC:   state_d = mac_tc ? ST_RELU : ST_LOAD;
         ST_RELU:  state_d = ST_PLOAD;
         ST_PLOAD: state_d = ST_DRAIN;
         ST_DRAIN: if (wr_fire && byte_tc) state_d = grp_tc ? ST_DONE : ST_CLEAR;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_hit) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge CLKEXT) begin
      if (RST_GLO) begin
         state_q    <= ST_IDLE;
         mac_last_q <= '0;
         grp_last_q <= '0;
         sel_con_q  <= SEL_AUTO;
      end else begin
         state_q    <= state_d;
         mac_last_q <= mac_last_d;
         grp_last_q <= grp_last_d;
         sel_con_q  <= sel_con_d;
      end
   end

   assign core.in_ready     = (state_q == ST_LOAD);
   assign core.EN_BUF_IN    = (state_q == ST_LOAD) && core.in_valid;
   assign core.CLR_BUF_IN   = (state_q == ST_CLEAR);
   assign core.RST_MAC      = (state_q == ST_CLEAR);
   assign core.CLR_PISO_OUT = (state_q == ST_CLEAR);
   assign core.EN_MAC       = (state_q == ST_MAC);
   assign core.EN_ReLU      = (state_q == ST_RELU);
   assign core.EN_PISO_OUT  = (state_q == ST_PLOAD);
   assign core.WR_EN        = wr_fire;
   assign core.SHIFT_OUT    = wr_fire;
   assign core.SEL_CON      = sel_con_q;
   assign CTR_OUT           = (state_q == ST_DRAIN);
   assign OUT_DONE          = (state_q == ST_DONE);
   assign busy              = (state_q != ST_IDLE);

`ifdef NPU_SEQ_PERF_EN
   logic [31:0] perf_cyc_q, perf_stl_q;
   logic        stall;

   assign stall = ((state_q == ST_LOAD) && !core.in_valid) ||
                  ((state_q == ST_DRAIN) && core.FULL);

   // Counting only non-IDLE cycles makes both values freeze once the job finishes.
   always_ff @(posedge CLKEXT) begin
      if (RST_GLO || start_acc) begin
         perf_cyc_q <= '0;
         perf_stl_q <= '0;
      end else begin
         if (busy && (perf_cyc_q != '1)) perf_cyc_q <= perf_cyc_q + 1'b1;
         if (stall && (perf_stl_q != '1)) perf_stl_q <= perf_stl_q + 1'b1;
      end
   end

   assign perf_cycles = perf_cyc_q;
   assign perf_stalls = perf_stl_q;
`endif

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// tb/tb_npu_seq_ctrl.sv - self-checking bench for npu_seq_ctrl against a step-script model
module tb_npu_seq_ctrl;

   localparam int K_IDLE = 0, K_CLR = 1, K_LD = 2, K_MAC = 3, K_RELU = 4,
                  K_PL = 5, K_DR = 6, K_DONE = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       manual_mode = 1'b0;
   logic [7:0] n_mac = 8'd1;
   logic [7:0] n_grp = 8'd1;
   logic       ctr_out, out_done, busy;
`ifdef NPU_SEQ_PERF_EN
   logic [31:0] perf_cycles, perf_stalls;
`endif

   npu_seq_ctrl_if bus ();

   npu_seq_ctrl dut (
      .CLKEXT      (clk),
      .RST_GLO     (rst),
      .start       (start),
      .abort       (abort),
      .manual_mode (manual_mode),
      .cfg_n_mac   (n_mac),
      .cfg_n_grp   (n_grp),
      .core        (bus),
      .CTR_OUT     (ctr_out),
      .OUT_DONE    (out_done),
`ifdef NPU_SEQ_PERF_EN
      .perf_cycles (perf_cycles),
      .perf_stalls (perf_stalls),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int  total = 0, bad = 0;
   int  cmp_total = 0, cmp_bad = 0;
   bit  chk_en = 0;
   int  mac_n = 0, relu_n = 0, wr_n = 0, done_n = 0, buf_n = 0;

   // The model is a script of pending steps built at job start; the head step is the expected phase.
   int  q[$];
   bit  sel_m = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         sel_m = 1'b1;
      end else if (q.size() == 0) begin
         if (start && !abort) begin
            int nm, ng;
            nm = (n_mac == 0) ? 1 : int'(n_mac);
            ng = (n_grp == 0) ? 1 : int'(n_grp);
            for (int g = 0; g < ng; g++) begin
               q.push_back(K_CLR);
               for (int m = 0; m < nm; m++) begin
                  q.push_back(K_LD);
                  q.push_back(K_MAC);
               end
               q.push_back(K_RELU);
               q.push_back(K_PL);
               for (int b = 0; b < 8; b++) q.push_back(K_DR);
            end
            q.push_back(K_DONE);
            sel_m = !manual_mode;
         end
      end else if (abort) begin
         q.delete();
      end else begin
         if (q[0] == K_LD) begin
            if (bus.in_valid) void'(q.pop_front());
         end else if (q[0] == K_DR) begin
            if (!bus.FULL) void'(q.pop_front());
         end else begin
            void'(q.pop_front());
         end
      end
   end

   function automatic logic [13:0] exp_vec(int k, logic v, logic f, logic s);
      logic ld, dr, cl;
      ld = (k == K_LD);
      dr = (k == K_DR);
      cl = (k == K_CLR);
      return {k != K_IDLE, ld, ld && v, cl, k == K_MAC, cl, k == K_RELU, k == K_PL, cl,
              dr && !f, dr && !f, s, dr, k == K_DONE};
   endfunction

   always @(negedge clk) begin
      logic [13:0] got, exp;
      int k;
      got = {busy, bus.in_ready, bus.EN_BUF_IN, bus.CLR_BUF_IN, bus.EN_MAC, bus.RST_MAC,
             bus.EN_ReLU, bus.EN_PISO_OUT, bus.CLR_PISO_OUT, bus.SHIFT_OUT, bus.WR_EN,
             bus.SEL_CON, ctr_out, out_done};
      if (chk_en) begin
         k = (q.size() != 0) ? q[0] : K_IDLE;
         exp = exp_vec(k, bus.in_valid, bus.FULL, sel_m);
         cmp_total++;
         if (got !== exp) begin
            cmp_bad++;
            $display("FAIL outputs t=%0t got=%b required=%b", $time, got, exp);
         end
      end
      if (bus.EN_MAC === 1'b1)    mac_n++;
      if (bus.EN_ReLU === 1'b1)   relu_n++;
      if (bus.WR_EN === 1'b1)     wr_n++;
      if (out_done === 1'b1)      done_n++;
      if (bus.EN_BUF_IN === 1'b1) buf_n++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int got, input int req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   task automatic start_job(input int nm, input int ng, input bit man);
      n_mac = 8'(nm);
      n_grp = 8'(ng);
      manual_mode = man;
      start = 1'b1;
      tick();
      start = 1'b0;
      manual_mode = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit gap, output int cyc);
      cyc = 1;
      while (!out_done && cyc < limit) begin
         if (gap) bus.in_valid = ((cyc % 5) == 4);
         tick();
         cyc++;
      end
      bus.in_valid = 1'b1;
      if (!out_done) check("done_timeout", 0, 1);
   endtask

   task automatic wait_writes(input int base, input int target);
      int n = 0;
      while ((wr_n - base) < target && n < 200) begin
         tick();
         n++;
      end
      if ((wr_n - base) < target) check("write_timeout", wr_n - base, target);
   endtask

   initial begin
      int cyc, b_mac, b_relu, b_wr, b_done, b_buf, n;
      bus.in_valid = 1'b1;
      bus.FULL     = 1'b0;
      tick();
      chk_en = 1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_sel_con", bus.SEL_CON, 1);
      check("rst_wr_en", bus.WR_EN, 0);

      // 1: three MAC steps, one group, no back-pressure
      b_mac = mac_n; b_relu = relu_n; b_wr = wr_n; b_done = done_n;
      start_job(3, 1, 0);
      wait_done(100, 0, cyc);
      check("t1_latency", cyc, 18);
      tick();
      check("t1_mac", mac_n - b_mac, 3);
      check("t1_relu", relu_n - b_relu, 1);
      check("t1_writes", wr_n - b_wr, 8);
      check("t1_done", done_n - b_done, 1);
`ifdef NPU_SEQ_PERF_EN
      check("t1_perf_cycles", int'(perf_cycles), 18);
`endif

      // 2: FIFO full for five cycles in the middle of group 0
      b_mac = mac_n; b_wr = wr_n; b_done = done_n;
      start_job(2, 2, 0);
      wait_writes(b_wr, 3);
      bus.FULL = 1'b1;
      repeat (5) tick();
      bus.FULL = 1'b0;
      check("t2_writes_held", wr_n - b_wr, 3);
      wait_done(200, 0, cyc);
      tick();
      check("t2_writes", wr_n - b_wr, 16);
      check("t2_mac", mac_n - b_mac, 4);
      check("t2_done", done_n - b_done, 1);
`ifdef NPU_SEQ_PERF_EN
      check("t2_perf_stalls", int'(perf_stalls), 5);
`endif

      // 3: operand gaps of four cycles
      b_mac = mac_n; b_buf = buf_n;
      start_job(3, 1, 0);
      wait_done(200, 1, cyc);
      tick();
      check("t3_mac", mac_n - b_mac, 3);
      check("t3_buf_in", buf_n - b_buf, 3);

      // 4: abort during the third write of group 0
      b_wr = wr_n; b_done = done_n;
      start_job(1, 2, 0);
      wait_writes(b_wr, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_busy", busy, 0);
      repeat (20) tick();
      check("t4_writes", wr_n - b_wr, 3);
      check("t4_done", done_n - b_done, 0);

      // 5: manual job with a zero step count
      b_mac = mac_n; b_wr = wr_n;
      start_job(0, 1, 1);
      check("t5_sel_con", bus.SEL_CON, 0);
      wait_done(100, 0, cyc);
      tick();
      check("t5_mac", mac_n - b_mac, 1);
      check("t5_writes", wr_n - b_wr, 8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_sel_after_rst", bus.SEL_CON, 1);

      // 6: start while busy is ignored; reset during MAC
      start_job(3, 1, 0);
      n_mac = 8'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (bus.EN_MAC !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("t6_reached_mac", bus.EN_MAC, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_strobes", int'({bus.in_ready, bus.EN_BUF_IN, bus.CLR_BUF_IN, bus.EN_MAC,
                                bus.RST_MAC, bus.EN_ReLU, bus.EN_PISO_OUT, bus.CLR_PISO_OUT,
                                bus.SHIFT_OUT, bus.WR_EN, ctr_out, out_done}), 0);
      check("t6_busy", busy, 0);
      repeat (5) tick();

      total += cmp_total;
      bad   += cmp_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
